ap_job_seq: RTL and testbench
=============================

# ap_job_seq

Upstream job sequencer for the associative processor array `AP_s`. It accepts a streamed operand job from the host core:
- column A words, then column B words, over a valid/ready handshake;
- one opcode (`cmd`) and one direction, latched at `start`.

It writes the operands into the AP columns, runs the AP in ap_mode until `ap_state_irq`, then reads column C back out over a second valid/ready stream. It owns every AP control pin, so the host never touches `ap_mode`, `sel_col`, `write_en` or `read_en` directly.

## Interface
- `WORD_SIZE`, 8, operand width; matches AP `WORD_SIZE`.
- `CELL_QUANT`, 512, words per column; the address width is AW = clog2(CELL_QUANT).
- `TIMEOUT_CYCLES`, 4096, watchdog limit in WAIT; used only with `AP_SEQ_TIMEOUT_EN`.

Ports:
- `clock` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: 1-cycle job request; sampled only in IDLE.
- `cmd_in` in 3: opcode, 0..6 = OR, XOR, AND, NOT, ADD, SUB, MULT.
- `dir_in` in 1: op_direction, 0 = vertical, 1 = horizontal.
- `in_valid` in 1, `in_data` in WORD_SIZE, `in_ready` out 1: operand stream.
- `out_valid` out 1, `out_data` out WORD_SIZE, `out_ready` in 1: result stream.
- `busy` out 1: high when not in IDLE.
- `done` out 1: 1-cycle pulse at job end.
- `err` out 1: sticky error flag; cleared by the next accepted `start`.
- `ap_addr` out AW, `ap_data` out WORD_SIZE: AP `addr_in`, `data_in`.
- `ap_mode`, `ap_op_direction`, `ap_sel_internal_col`, `ap_write_en`, `ap_read_en` out 1 each.
- `ap_cmd` out 3, `ap_sel_col` out 2.
- `ap_data_out` in WORD_SIZE, `ap_irq` in 1: AP `data_out`, `ap_state_irq`.

## Operation
States, in order:
- **IDLE**
  - `start` with `cmd_in` ≤ 6: latch cmd/dir, clear `err`, set word counter = 0, go to LOAD_A.
  - `start` with `cmd_in` = 7: set `err`, pulse `done`, stay in IDLE.
- **LOAD_A / LOAD_B**
  - `in_ready` = 1.
  - On each `in_valid & in_ready` beat, in the same cycle: `ap_write_en` = 1, `ap_sel_col` = 0 (A) or 1 (B), `ap_addr` = counter, `ap_data` = `in_data`.
  - Counter increments per beat.
  - After beat CELL_QUANT-1, the counter wraps to 0 and the state advances (A → B → ARM).
- **ARM**: one cycle; `ap_cmd` and `ap_op_direction` are driven, `ap_mode` = 0. This guarantees cmd is stable one cycle before `ap_mode` rises.
- **WAIT**: `ap_mode` = 1, held continuously; exit on `ap_irq` = 1 to RD_ISSUE with `ap_mode` = 0 from the next cycle.
- **RD_ISSUE**: `ap_read_en` = 1, `ap_sel_col` = 2, `ap_addr` = counter, for one cycle.
- **RD_WAIT**: two cycles; no AP strobes; `ap_sel_col` and `ap_addr` held.
- **RD_OUT**
  - Entry: capture `ap_data_out` into `out_data`, assert `out_valid`.
  - Hold both until `out_ready`.
  - On handshake: if counter = CELL_QUANT-1, go to FIN; else increment and go to RD_ISSUE.
- **FIN**: pulse `done`, return to IDLE.

Output rules:
- `ap_cmd` and `ap_op_direction` are held from ARM through FIN.
- `ap_write_en` and `ap_read_en` are never both 1.
- `ap_write_en` is never 1 while `ap_mode` = 1.
- `ap_sel_internal_col` is tied 0.

## Timing
- Reset values (all outputs):
  - 0: `in_ready`, `out_valid`, `out_data`, `busy`, `done`, `err`, `ap_mode`, `ap_write_en`, `ap_read_en`, `ap_addr`, `ap_data`, `ap_cmd`, `ap_sel_col`, `ap_op_direction`.
  - State = IDLE.
- Reset mid-job: any state returns to IDLE next cycle, and `ap_mode` drops immediately, which also resets the AP FSM. No `done` pulse.
- Load throughput: one word per cycle at full `in_valid`. `in_ready` deasserts in the cycle after the final B beat.
- Readback: 4 cycles per word (ISSUE, WAIT×2, OUT) at full `out_ready`. `ap_data_out` is sampled exactly 3 edges after the `read_en` edge.
- Simultaneous `ap_irq` and entry to WAIT: the irq is honoured; minimum WAIT length is 1 cycle.
- `start` while busy: ignored, no effect.

## Configuration
- Macro `AP_SEQ_TIMEOUT_EN`.
- Defined:
  - A WAIT cycle counter (clog2(TIMEOUT_CYCLES)+1 bits) clears on WAIT entry.
  - If it reaches TIMEOUT_CYCLES without `ap_irq`: set `err`, drop `ap_mode`, skip readback, go to FIN (`done` pulses).
- Undefined: no counter; WAIT lasts indefinitely until `ap_irq` or `rst`.

## Test plan
- CELL_QUANT = 4, cmd 4 (ADD), A = {1,2,3,250}, B = {1,2,4,10} → writes to A addr 0..3 then B addr 0..3. With an AP model asserting irq after 20 cycles, reads C → `out_data` = {2,4,7,4} (low 8 bits), then a `done` pulse.
- `cmd_in` = 7 with `start` → `err` = 1 and `done` pulse next cycle; `in_ready` stays 0, no AP strobe.
- Throttle: `in_valid` toggling 1/0 and `out_ready` low for 5 cycles per word → no lost or duplicated words; `ap_addr` sequence 0..3 exactly once per column.
- `rst` asserted in WAIT → next cycle `ap_mode` = 0, `busy` = 0, no `done`; a following job completes normally.
- With `AP_SEQ_TIMEOUT_EN`, TIMEOUT_CYCLES = 16, `ap_irq` never asserted → at WAIT cycle 16 `err` = 1, `done` pulse, `out_valid` never asserted.
- Protocol checker throughout: `ap_write_en & ap_mode` = 0; `ap_cmd` is stable for ≥ 1 cycle before `ap_mode` rises.

Source files
------------

// File: rtl/ap_job_seq.sv
// ap_job_seq: upstream job sequencer for the associative processor array.
// Streams column A then column B into the AP, arms the opcode, runs the AP
// until it raises its irq, then streams column C back out. This block is the
// sole driver of every AP control pin.
// Optional build macro: AP_SEQ_TIMEOUT_EN adds a watchdog on the WAIT state
// that flags err and finishes the job after TIMEOUT_CYCLES without irq.
module ap_job_seq #(
  parameter  int WORD_SIZE      = 8,
  parameter  int CELL_QUANT     = 512,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int AW             = $clog2(CELL_QUANT)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           cmd_in,
  input  logic                 dir_in,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out_data,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [AW-1:0]        ap_addr,
  output logic [WORD_SIZE-1:0] ap_data,
  output logic                 ap_mode,
  output logic                 ap_op_direction,
  output logic                 ap_sel_internal_col,
  output logic                 ap_write_en,
  output logic                 ap_read_en,
  output logic [2:0]           ap_cmd,
  output logic [1:0]           ap_sel_col,
  input  logic [WORD_SIZE-1:0] ap_data_out,
  input  logic                 ap_irq
);

  if (CELL_QUANT < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ap_job_seq: CELL_QUANT must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  localparam logic [AW-1:0] LAST_ADDR = AW'(CELL_QUANT - 1);
  localparam logic [2:0]    CMD_BAD   = 3'd7;
  localparam logic [1:0]    COL_A     = 2'd0;
  localparam logic [1:0]    COL_B     = 2'd1;
  localparam logic [1:0]    COL_C     = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_ARM,
    S_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_OUT,
    S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [2:0]           cmd_q, cmd_d;
  logic                 dir_q, dir_d;
  logic                 err_q, err_d;
  logic                 bad_done_q, bad_done_d;
  logic                 rd_ph_q, rd_ph_d;
  logic [WORD_SIZE-1:0] out_data_q, out_data_d;

`ifdef AP_SEQ_TIMEOUT_EN
  localparam int        TW      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]        to_cnt_q, to_cnt_d;
`endif

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      bad_done_q <= 1'b0;
      rd_ph_q    <= 1'b0;
      out_data_q <= '0;
`ifdef AP_SEQ_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      bad_done_q <= bad_done_d;
      rd_ph_q    <= rd_ph_d;
      out_data_q <= out_data_d;
`ifdef AP_SEQ_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  // Next-state logic: job sequencing, word counter and error tracking.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    dir_d      = dir_q;
    err_d      = err_q;
    bad_done_d = 1'b0;
    rd_ph_d    = rd_ph_q;
    out_data_d = out_data_q;
`ifdef AP_SEQ_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cmd_in == CMD_BAD) begin
            err_d      = 1'b1;
            bad_done_d = 1'b1;
          end else begin
            cmd_d   = cmd_in;
            dir_d   = dir_in;
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_LOAD_A;
          end
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        if (in_valid) begin
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_ARM;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ARM: begin
        state_d = S_WAIT;
`ifdef AP_SEQ_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (ap_irq) begin
          state_d = S_RD_ISSUE;
`ifdef AP_SEQ_TIMEOUT_EN
        end else if (to_cnt_q == TO_LAST) begin
          // This is the TIMEOUT_CYCLES-th WAIT cycle without irq.
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      S_RD_ISSUE: begin
        rd_ph_d = 1'b0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Second wait cycle ends on the third edge after the read strobe,
        // which is when the AP data_out is valid.
        if (rd_ph_q) begin
          out_data_d = ap_data_out;
          state_d    = S_RD_OUT;
        end else begin
          rd_ph_d = 1'b1;
        end
      end
      S_RD_OUT: begin
        if (out_ready) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = S_FIN;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_RD_ISSUE;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: AP control pins and stream handshakes from the state.
  always_comb begin
    in_ready            = 1'b0;
    out_valid           = 1'b0;
    ap_addr             = '0;
    ap_data             = '0;
    ap_mode             = 1'b0;
    ap_op_direction     = 1'b0;
    ap_write_en         = 1'b0;
    ap_read_en          = 1'b0;
    ap_cmd              = 3'd0;
    ap_sel_col          = COL_A;
    unique case (state_q)
      S_LOAD_A, S_LOAD_B: begin
        in_ready   = 1'b1;
        ap_sel_col = (state_q == S_LOAD_A) ? COL_A : COL_B;
        ap_addr    = cnt_q;
        if (in_valid) begin
          ap_write_en = 1'b1;
          ap_data     = in_data;
        end
      end
      S_RD_ISSUE, S_RD_WAIT, S_RD_OUT: begin
        ap_sel_col = COL_C;
        ap_addr    = cnt_q;
        ap_read_en = (state_q == S_RD_ISSUE);
        out_valid  = (state_q == S_RD_OUT);
      end
      default: ;
    endcase
    // Opcode is presented from ARM onward so it is stable before ap_mode rises.
    if (state_q inside {S_ARM, S_WAIT, S_RD_ISSUE, S_RD_WAIT, S_RD_OUT, S_FIN}) begin
      ap_cmd          = cmd_q;
      ap_op_direction = dir_q;
    end
    // Reset drops ap_mode in the same cycle so the AP FSM aborts with us.
    ap_mode = (state_q == S_WAIT) && !rst;
  end

  assign ap_sel_internal_col = 1'b0;
  assign out_data            = out_data_q;
  assign busy                = (state_q != S_IDLE);
  assign err                 = err_q;
  assign done                = !rst && (bad_done_q || state_q == S_FIN);

endmodule

// File: tb/tb_ap_job_seq.sv
// Self-checking bench for ap_job_seq with a behavioural AP model.
module tb_ap_job_seq;
  localparam int WS = 8;
  localparam int CQ = 4;
  localparam int TO = 16;
  localparam int AW = $clog2(CQ);

  logic          clock = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    cmd_in;
  logic          dir_in;
  logic          in_valid;
  logic [WS-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [WS-1:0] out_data;
  logic          out_ready;
  logic          busy, done, err;
  logic [AW-1:0] ap_addr;
  logic [WS-1:0] ap_data;
  logic          ap_mode, ap_op_direction, ap_sel_internal_col;
  logic          ap_write_en, ap_read_en;
  logic [2:0]    ap_cmd;
  logic [1:0]    ap_sel_col;
  logic [WS-1:0] ap_data_out;
  logic          ap_irq;

  always #5 clock = ~clock;

  ap_job_seq #(.WORD_SIZE(WS), .CELL_QUANT(CQ), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .rst(rst), .start(start), .cmd_in(cmd_in), .dir_in(dir_in),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err),
    .ap_addr(ap_addr), .ap_data(ap_data), .ap_mode(ap_mode),
    .ap_op_direction(ap_op_direction), .ap_sel_internal_col(ap_sel_internal_col),
    .ap_write_en(ap_write_en), .ap_read_en(ap_read_en), .ap_cmd(ap_cmd),
    .ap_sel_col(ap_sel_col), .ap_data_out(ap_data_out), .ap_irq(ap_irq)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Element-wise AP operation: the result the host expects in column C.
  function automatic logic [7:0] alu(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      3'd0:    return a | b;
      3'd1:    return a ^ b;
      3'd2:    return a & b;
      3'd3:    return ~a;
      3'd4:    return a + b;
      3'd5:    return a - b;
      3'd6:    return a * b;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- behavioural AP model ----------------
  logic [7:0] col_a [CQ];
  logic [7:0] col_b [CQ];
  logic [7:0] rd_val;
  int         rd_cnt   = 0;
  int         mode_cnt = 0;
  int         irq_lat  = 20;
  bit         irq_en   = 1'b1;

  always @(posedge clock) begin
    if (ap_write_en && ap_sel_col == 2'd0) col_a[ap_addr] <= ap_data;
    if (ap_write_en && ap_sel_col == 2'd1) col_b[ap_addr] <= ap_data;
    mode_cnt <= ap_mode ? mode_cnt + 1 : 0;
    if (ap_read_en) begin
      rd_val <= alu(ap_cmd, col_a[ap_addr], col_b[ap_addr]);
      rd_cnt <= 1;
    end else if (rd_cnt != 0 && rd_cnt < 3) begin
      rd_cnt <= rd_cnt + 1;
    end else begin
      rd_cnt <= 0;
    end
  end

  // Read data is only correct in the window sampled by the third edge.
  assign ap_data_out = (rd_cnt == 2) ? rd_val : ~rd_val;
  assign ap_irq      = irq_en && ap_mode && (mode_cnt >= irq_lat);

  // ---------------- protocol monitor ----------------
  logic [2:0] job_cmd = 3'd0;
  logic       job_dir = 1'b0;
  logic [2:0] prev_cmd = 3'd0;
  logic       prev_mode = 1'b0;

  always @(negedge clock) begin
    check("wr_and_mode", ap_write_en & ap_mode, 0);
    check("wr_and_rd", ap_write_en & ap_read_en, 0);
    check("sel_internal", ap_sel_internal_col, 0);
    if (ap_mode && !prev_mode) begin
      check("cmd_stable_before_mode", prev_cmd, ap_cmd);
      check("cmd_value", ap_cmd, job_cmd);
      check("dir_value", ap_op_direction, job_dir);
    end
    prev_cmd  <= ap_cmd;
    prev_mode <= ap_mode;
  end

  // ---------------- job driver ----------------
  logic [7:0] wa [CQ];
  logic [7:0] wb [CQ];

  // vpat: 0 = in_valid always, 1 = toggling, 2 = random. gap: out_ready low
  // cycles per result word. lat: irq latency in WAIT cycles.
  task automatic run_job(input logic [2:0] c, input logic d, input int vpat,
                         input int gap, input int lat);
    logic [7:0] words [2*CQ];
    logic [7:0] expv [CQ];
    int idx = 0, oidx = 0, rdi = 0, ov_cnt = 0, cyc = 0;
    bit done_seen = 1'b0;
    for (int i = 0; i < CQ; i++) begin
      words[i]      = wa[i];
      words[CQ + i] = wb[i];
      expv[i]       = alu(c, wa[i], wb[i]);
    end
    irq_lat = lat;
    irq_en  = 1'b1;
    job_cmd = c;
    job_dir = d;
    start = 1'b1; cmd_in = c; dir_in = d;
    @(posedge clock); #1;
    start = 1'b0;
    check("job_busy", busy, 1);
    check("job_err_clear", err, 0);
    while (!done_seen && cyc < 3000) begin
      in_valid  = (idx < 2*CQ) && (vpat == 0 || (vpat == 1 && cyc % 2 == 0) ||
                                   (vpat == 2 && $urandom_range(1) == 1));
      in_data   = (idx < 2*CQ) ? words[idx] : 8'h00;
      out_ready = (ov_cnt >= gap);
      @(negedge clock);
      if (idx == 2*CQ) check("in_ready_after_load", in_ready, 0);
      check("wr_strobe", ap_write_en, in_valid & in_ready);
      if (in_valid && in_ready) begin
        check("wr_addr", ap_addr, idx % CQ);
        check("wr_col", ap_sel_col, (idx < CQ) ? 0 : 1);
        check("wr_data", ap_data, words[idx]);
        idx++;
      end
      if (ap_read_en) begin
        check("rd_addr", ap_addr, rdi);
        check("rd_col", ap_sel_col, 2);
        rdi++;
      end
      if (out_valid) ov_cnt++;
      if (out_valid && out_ready) begin
        check("out_data", out_data, expv[oidx % CQ]);
        oidx++;
        ov_cnt = 0;
      end
      if (done) done_seen = 1'b1;
      @(posedge clock); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("job_done_seen", done_seen, 1);
    check("job_write_count", idx, 2*CQ);
    check("job_read_count", rdi, CQ);
    check("job_out_count", oidx, CQ);
    check("post_done_pulse", done, 0);
    check("post_busy", busy, 0);
    check("post_err", err, 0);
  endtask

  typedef struct {
    logic       start;
    logic [2:0] cmd;
    logic       do_rst;
    logic       busy;
    logic       in_ready;
    logic       err;
    logic       done;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode_cycles;
    bit ov_seen;
    rst = 1'b1; start = 1'b0; cmd_in = 3'd0; dir_in = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ctrl", {in_ready, out_valid, busy, done, err, ap_mode, ap_write_en,
                       ap_read_en, ap_op_direction, ap_sel_internal_col}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_ap_addr", ap_addr, 0);
    check("rst_ap_data", ap_data, 0);
    check("rst_ap_cmd", ap_cmd, 0);
    check("rst_sel_col", ap_sel_col, 0);
    rst = 1'b0;

    // start/cmd handling in IDLE: {start, cmd, rst_after, busy, in_ready, err, done}
    vecs[0] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      start = vecs[i].start; cmd_in = vecs[i].cmd;
      @(posedge clock); #1;
      start = 1'b0;
      check("vec_busy", busy, vecs[i].busy);
      check("vec_in_ready", in_ready, vecs[i].in_ready);
      check("vec_err", err, vecs[i].err);
      check("vec_done", done, vecs[i].done);
      check("vec_no_strobe", {ap_write_en, ap_read_en, ap_mode}, 0);
      if (vecs[i].do_rst) begin
        rst = 1'b1;
        @(posedge clock); #1;
        rst = 1'b0;
        check("vec_rst_idle", {busy, err, done}, 0);
      end
    end

    // Directed ADD job with fixed operands and 20-cycle AP latency.
    wa = '{8'd1, 8'd2, 8'd3, 8'd250};
    wb = '{8'd1, 8'd2, 8'd4, 8'd10};
    run_job(3'd4, 1'b0, 0, 0, 20);

    // Throttled job: toggling in_valid, out_ready low 5 cycles per word.
    for (int i = 0; i < CQ; i++) begin
      wa[i] = 8'($urandom); wb[i] = 8'($urandom);
    end
    run_job(3'd5, 1'b1, 1, 5, 3);

    // Reset in WAIT, then a clean job.
    irq_en = 1'b0;
    job_cmd = 3'd2; job_dir = 1'b0;
    start = 1'b1; cmd_in = 3'd2; dir_in = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    begin
      bit in_wait = 1'b0;
      for (int c = 0; c < 50 && !in_wait; c++) begin
        in_valid = 1'b1; in_data = 8'($urandom);
        @(negedge clock);
        if (ap_mode) in_wait = 1'b1;
        else begin @(posedge clock); #1; end
      end
      check("reached_wait", in_wait, 1);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mode_immediate", ap_mode, 0);
    @(posedge clock); #1;
    rst = 1'b0;
    check("rst_wait_idle", {busy, ap_mode, done, in_ready}, 0);
    @(posedge clock); #1;
    check("rst_wait_no_done", {done, busy}, 0);
    irq_en = 1'b1;
    for (int i = 0; i < CQ; i++) begin
      wa[i] = 8'($urandom); wb[i] = 8'($urandom);
    end
    run_job(3'd6, 1'b0, 0, 0, 2);

    // Randomized jobs; first one has irq at WAIT entry.
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < CQ; i++) begin
        wa[i] = 8'($urandom); wb[i] = 8'($urandom);
      end
      run_job(3'($urandom_range(6)), 1'($urandom_range(1)), j % 3,
              $urandom_range(3), (j == 0) ? 0 : $urandom_range(6));
    end

`ifdef AP_SEQ_TIMEOUT_EN
    // Watchdog: irq never comes, job ends after TO WAIT cycles with err.
    irq_en = 1'b0;
    job_cmd = 3'd1; job_dir = 1'b1;
    start = 1'b1; cmd_in = 3'd1; dir_in = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    mode_cycles = 0;
    ov_seen = 1'b0;
    begin
      bit fin = 1'b0;
      for (int c = 0; c < 200 && !fin; c++) begin
        in_valid = 1'b1; in_data = 8'($urandom);
        @(negedge clock);
        if (ap_mode) mode_cycles++;
        if (out_valid) ov_seen = 1'b1;
        if (done) begin
          fin = 1'b1;
          check("to_err", err, 1);
          check("to_mode_low", ap_mode, 0);
        end
        @(posedge clock); #1;
      end
      check("to_done_seen", fin, 1);
    end
    in_valid = 1'b0;
    check("to_wait_len", mode_cycles, TO);
    check("to_no_out_valid", ov_seen, 0);
    irq_en = 1'b1;
`else
    mode_cycles = 0;
    ov_seen = 1'b0;
`endif

    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
